avalon_slave_mem: RTL

- Avalon memory-mapped slave (responder) memory for the MIPS CPU's bus master port; the counterpart that answers the CPU's read/write/waitrequest handshake.
- Adds a programmable number of wait states, byte-lane writes and a backdoor word-load port so benches can preload programs before releasing the CPU.
- Sits beside top_level_cpu in CPU testbenches and integration tops.

---
 rtl/avalon_slave_mem_if.sv | 21 ++
 rtl/avalon_slave_mem.sv | 118 +++++++++++
 2 files changed

// File: rtl/avalon_slave_mem_if.sv
// Avalon-MM bus bundle between the CPU master port and avalon_slave_mem.
// The master drives the request fields. The slave answers with waitrequest and readdata.
interface avalon_slave_mem_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_slave_mem.sv
// Avalon-MM responder memory with programmable wait states, byte-lane writes
// and a backdoor word-load port for preloading programs.
//
// state  | meaning
// S_IDLE | no transfer in progress; a request starts the wait sequence
// S_WAIT | counting wait states; a dropped request aborts the transfer
// S_ACK  | waitrequest low; read data valid; write commits at the closing edge
module avalon_slave_mem #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    avalon_slave_mem_if.slave   bus,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [31:0]         load_data
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       readdata_q;
    logic [31:0]       mem_q [2**ADDR_W];

    logic              req;
    logic [ADDR_W-1:0] idx;
    logic              rd_capture;
    logic              wr_commit;
    logic              unused_addr_bits;

    assign req              = bus.read | bus.write;
    assign idx              = bus.address[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.address[31:ADDR_W+2], bus.address[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (rd_capture) begin
                readdata_q <= mem_q[idx];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req && !load_en) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    // a backdoor load holds the request here until it is released
                    if (!load_en) begin
                        state_d = S_ACK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.waitrequest = req && (state_q != S_ACK);
        // a simultaneous read+write is a write; readdata keeps its old value
        rd_capture      = (state_q != S_ACK) && (state_d == S_ACK) && bus.read && !bus.write;
        wr_commit       = (state_q == S_ACK) && bus.write;
    end

    assign bus.readdata = readdata_q;

    // Memory is deliberately not reset; reset forces IDLE, which blocks any commit.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    mem_q[idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

endmodule
